// File: rtl/mvm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mvm_pkg
// Description : Shared types and constants for the sparse MVM host driver.
//               Holds the sequencer state encoding, the matrix geometry and
//               helpers that split a row-major entry index into row/col.
// Revision    : 1.0 - initial release
// ============================================================================
package mvm_pkg;

  localparam int MVM_DIM      = 4;
  localparam int MVM_IDX_W    = 4;
  localparam int MVM_VAL_W    = 8;
  localparam int MVM_RC_W     = 2;
  localparam int MVM_LAST_IDX = MVM_DIM * MVM_DIM - 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SCAN      = 3'd1,
    ST_SEND      = 3'd2,
    ST_LIST_DONE = 3'd3,
    ST_COLLECT   = 3'd4,
    ST_FINISH    = 3'd5
  } mvm_state_e;

  // Row-major index: upper bits select the row, lower bits the column.
  function automatic logic [MVM_RC_W-1:0] mvm_idx_row(input logic [MVM_IDX_W-1:0] idx);
    return idx[MVM_IDX_W-1:MVM_RC_W];
  endfunction

  function automatic logic [MVM_RC_W-1:0] mvm_idx_col(input logic [MVM_IDX_W-1:0] idx);
    return idx[MVM_RC_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mvm_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : mvm_result_collector
// Description : Captures the four result values streamed back by the
//               accelerator into a small register file and provides a
//               combinational read port.
// Ports       : clk, rst_n        - clock, async active-low reset
//               clear             - reset the write pointer (start of collection)
//               capture           - store capture_data at the write pointer
//               capture_data[7:0] - incoming result value
//               res_addr[1:0]     - read select
//               res_data[7:0]     - result register res_addr (combinational)
//               complete          - this capture fills the last register
// Revision    : 1.0 - initial release
// ============================================================================
module mvm_result_collector
  import mvm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 capture,
  input  logic [MVM_VAL_W-1:0] capture_data,
  input  logic [MVM_RC_W-1:0]  res_addr,
  output logic [MVM_VAL_W-1:0] res_data,
  output logic                 complete
);

  logic [MVM_RC_W-1:0]  r_ptr;
  logic [MVM_VAL_W-1:0] r_res [MVM_DIM];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      for (int i = 0; i < MVM_DIM; i++) begin
        r_res[i] <= '0;
      end
    end else if (clear) begin
      // Only the pointer is cleared: old results stay readable until
      // they are overwritten by the next collection.
      r_ptr <= '0;
    end else if (capture) begin
      r_res[r_ptr] <= capture_data;
      r_ptr        <= r_ptr + 1'b1;
    end
  end

  assign complete = capture && (r_ptr == MVM_RC_W'(MVM_DIM - 1));
  assign res_data = r_res[res_addr];

endmodule
`default_nettype wire

// File: rtl/mvm_host_driver.sv
`default_nettype none
// ============================================================================
// Module      : mvm_host_driver
// Description : Host-side sequencer for the sparse matrix-vector accelerator.
//               Holds a 4x4 matrix of 8-bit values written over a register
//               port; on start it streams (row, col, value) entries in
//               row-major order, signals end-of-list and collects the four
//               results returned by the accelerator. A watchdog aborts any
//               wait on the accelerator after MAX_WAIT cycles.
// Config      : MVM_HOST_SKIP_ZERO_EN - when defined, zero-valued entries are
//               skipped (sparse transfer); otherwise all 16 entries are sent.
// Ports       : clk, rst_n                  - clock, async active-low reset
//               cfg_we/cfg_addr/cfg_data    - matrix write port (IDLE only)
//               start                       - begin transfer (level, IDLE only)
//               busy, done, error           - status (done is a pulse)
//               res_addr, res_data          - result read port
//               acc_row/acc_col/acc_value   - entry to the accelerator
//               acc_sending_cpu             - entry valid
//               acc_done_list               - end-of-list pulse
//               acc_fetch_ready             - accelerator ready
//               acc_sending_out, acc_output_val - result stream
// Revision    : 1.0 - initial release
// ============================================================================
module mvm_host_driver
  import mvm_pkg::*;
#(
  parameter logic [23:0] MAX_WAIT = 24'd10_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [MVM_IDX_W-1:0] cfg_addr,
  input  logic [MVM_VAL_W-1:0] cfg_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  input  logic [MVM_RC_W-1:0]  res_addr,
  output logic [MVM_VAL_W-1:0] res_data,
  output logic [MVM_RC_W-1:0]  acc_row,
  output logic [MVM_RC_W-1:0]  acc_col,
  output logic [MVM_VAL_W-1:0] acc_value,
  output logic                 acc_sending_cpu,
  output logic                 acc_done_list,
  input  logic                 acc_fetch_ready,
  input  logic                 acc_sending_out,
  input  logic [MVM_VAL_W-1:0] acc_output_val
);

  localparam logic [MVM_IDX_W-1:0] c_LAST_IDX = MVM_IDX_W'(MVM_LAST_IDX);

  mvm_state_e           r_state;
  logic [MVM_IDX_W-1:0] r_idx;
  logic [23:0]          r_wait;
  logic [MVM_VAL_W-1:0] r_matrix [MVM_DIM*MVM_DIM];

  logic [MVM_VAL_W-1:0] w_entry;
  logic                 w_send_entry;
  logic                 w_timeout;
  logic                 w_capture;
  logic                 w_clear_ptr;
  logic                 w_complete;

  assign w_entry = r_matrix[r_idx];

`ifdef MVM_HOST_SKIP_ZERO_EN
  assign w_send_entry = (w_entry != '0);
`else
  assign w_send_entry = 1'b1;
`endif

  // r_wait counts cycles already spent waiting; the current cycle is the
  // MAX_WAIT-th one when r_wait + 1 reaches the limit.
  assign w_timeout   = ((r_wait + 24'd1) >= MAX_WAIT);
  assign w_capture   = (r_state == ST_COLLECT) && acc_sending_out;
  assign w_clear_ptr = (r_state == ST_LIST_DONE) && acc_fetch_ready;

  mvm_result_collector u_collector (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (w_clear_ptr),
    .capture      (w_capture),
    .capture_data (acc_output_val),
    .res_addr     (res_addr),
    .res_data     (res_data),
    .complete     (w_complete)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_idx           <= '0;
      r_wait          <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
      acc_row         <= '0;
      acc_col         <= '0;
      acc_value       <= '0;
      acc_sending_cpu <= 1'b0;
      acc_done_list   <= 1'b0;
      for (int i = 0; i < MVM_DIM * MVM_DIM; i++) begin
        r_matrix[i] <= '0;
      end
    end else begin
      // Pulse outputs fall back to 0 unless a branch below re-asserts them.
      done          <= 1'b0;
      acc_done_list <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (cfg_we) begin
            r_matrix[cfg_addr] <= cfg_data;
          end
          if (start) begin
            r_idx   <= '0;
            error   <= 1'b0;
            busy    <= 1'b1;
            r_state <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          r_wait <= '0;
          if (w_send_entry) begin
            acc_row         <= mvm_idx_row(r_idx);
            acc_col         <= mvm_idx_col(r_idx);
            acc_value       <= w_entry;
            acc_sending_cpu <= 1'b1;
            r_state         <= ST_SEND;
          end else if (r_idx == c_LAST_IDX) begin
            r_state <= ST_LIST_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end

        ST_SEND: begin
          if (acc_fetch_ready) begin
            acc_sending_cpu <= 1'b0;
            r_wait          <= '0;
            if (r_idx == c_LAST_IDX) begin
              r_state <= ST_LIST_DONE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= ST_SCAN;
            end
          end else if (w_timeout) begin
            error           <= 1'b1;
            done            <= 1'b1;
            acc_sending_cpu <= 1'b0;
            r_state         <= ST_FINISH;
          end else begin
            r_wait <= r_wait + 24'd1;
          end
        end

        ST_LIST_DONE: begin
          if (acc_fetch_ready) begin
            acc_done_list <= 1'b1;
            r_wait        <= '0;
            r_state       <= ST_COLLECT;
          end else if (w_timeout) begin
            error   <= 1'b1;
            done    <= 1'b1;
            r_state <= ST_FINISH;
          end else begin
            r_wait <= r_wait + 24'd1;
          end
        end

        ST_COLLECT: begin
          if (w_complete) begin
            done    <= 1'b1;
            r_state <= ST_FINISH;
          end else if (w_capture) begin
            r_wait <= '0;
          end else if (w_timeout) begin
            error   <= 1'b1;
            done    <= 1'b1;
            r_state <= ST_FINISH;
          end else begin
            r_wait <= r_wait + 24'd1;
          end
        end

        ST_FINISH: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
